issue_select: RTL and testbench

- Issue scheduler in front of the bypass/dispatch stage.
- Holds up to DEPTH renamed micro-ops in a collapsing queue and tracks operand readiness by snooping two writeback tag buses.
- Each cycle it selects up to two ready, oldest-first instructions for the two routed issue slots.
- It guarantees the two slots never target the same functional unit, because the downstream per-unit outputs are OR-combined.
- It also tracks the multi-cycle divider so that nothing is issued to it while it is busy.

---
 rtl/issue_select_pkg.sv | 45 ++++
 rtl/issue_entry.sv | 65 ++++++
 rtl/issue_select.sv | 186 ++++++++++++++++++
 tb/tb_issue_select.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/issue_select_pkg.sv
// issue_select_pkg: shared definitions for the issue scheduler.
//   - unit codes used on the routing ctrl field
//   - packed entry layout {instr, unit, rs1, rs2, r1, r2} and its width
//   - wakeup tag compare shared by the enqueue path and the queue slots
package issue_select_pkg;

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_LSU = 2'd2;
  localparam logic [1:0] UNIT_DIV = 2'd3;

  // Tags are zero-extended to this width before comparing.
  localparam int TAG_MAX_W = 16;

  // Entry bit layout, LSB first: r2, r1, rs2, rs1, unit, instr.
  localparam int OFF_R2  = 0;
  localparam int OFF_R1  = 1;
  localparam int OFF_RS2 = 2;

  function automatic int off_rs1(input int width_reg);
    return 2 + width_reg;
  endfunction

  function automatic int off_unit(input int width_reg);
    return 2 + 2 * width_reg;
  endfunction

  function automatic int off_instr(input int width_reg);
    return 4 + 2 * width_reg;
  endfunction

  function automatic int entry_w(input int width, input int width_reg);
    return width + 4 + 2 * width_reg;
  endfunction

  // Tag 0 is the hardwired-ready register, so a wakeup on tag 0 means nothing.
  function automatic logic wake_match(input logic [TAG_MAX_W-1:0] tag,
                                      input logic                 v0,
                                      input logic [TAG_MAX_W-1:0] t0,
                                      input logic                 v1,
                                      input logic [TAG_MAX_W-1:0] t1);
    return (tag != '0) && ((v0 && (t0 == tag)) || (v1 && (t1 == tag)));
  endfunction

endpackage

// File: rtl/issue_entry.sv
// issue_entry: one slot of the collapsing issue queue.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           invalidate this slot next edge
//   src_sel         0 hold, 1 take slot+1, 2 take slot+2, 3 take new entry
//   d_valid         slot is occupied after this edge
//   in_p1/in_p2     packed contents of slot+1 / slot+2
//   in_new          packed new entry (ready bits = tag==0)
//   wb_*            two writeback wakeup buses
//   q_valid, q      registered slot contents
module issue_entry #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_REG = 5,
  parameter int EW        = issue_select_pkg::entry_w(WIDTH, WIDTH_REG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [1:0]           src_sel,
  input  logic                 d_valid,
  input  logic [EW-1:0]        in_p1,
  input  logic [EW-1:0]        in_p2,
  input  logic [EW-1:0]        in_new,
  input  logic                 wb_valid0,
  input  logic [WIDTH_REG-1:0] wb_tag0,
  input  logic                 wb_valid1,
  input  logic [WIDTH_REG-1:0] wb_tag1,
  output logic                 q_valid,
  output logic [EW-1:0]        q
);
  import issue_select_pkg::*;

  localparam int OFF_RS1 = off_rs1(WIDTH_REG);

  logic [EW-1:0] d;

  // Wakeup is applied to whatever lands in the slot, so an entry that moves
  // during collapse still catches a same-cycle writeback.
  always_comb begin
    d = q;
    unique case (src_sel)
      2'd1:    d = in_p1;
      2'd2:    d = in_p2;
      2'd3:    d = in_new;
      default: d = q;
    endcase
    d[OFF_R1] = d[OFF_R1] | wake_match(TAG_MAX_W'(d[OFF_RS1 +: WIDTH_REG]),
                                       wb_valid0, TAG_MAX_W'(wb_tag0),
                                       wb_valid1, TAG_MAX_W'(wb_tag1));
    d[OFF_R2] = d[OFF_R2] | wake_match(TAG_MAX_W'(d[OFF_RS2 +: WIDTH_REG]),
                                       wb_valid0, TAG_MAX_W'(wb_tag0),
                                       wb_valid1, TAG_MAX_W'(wb_tag1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else begin
      q_valid <= d_valid && !flush;
      q       <= d;
    end
  end

endmodule

// File: rtl/issue_select.sv
// issue_select: dual-issue, oldest-first scheduler over a collapsing queue.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_flush                  drop every queued entry
//   i_valid/o_ready          enqueue handshake (o_ready from registered count)
//   i_instr,i_unit,i_rs1,i_rs2  new micro-op
//   i_wb_valid0/1,i_wb_tag0/1   wakeup buses
//   o_valid1/2,o_instr1/2,o_unit1/2  two issue slots, registered
//   o_count                  registered occupancy
module issue_select #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_REG = 5,
  parameter int DEPTH     = 8,
  parameter int DIV_UNIT  = 3,
  parameter int DIV_LAT   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_instr,
  input  logic [1:0]                 i_unit,
  input  logic [WIDTH_REG-1:0]       i_rs1,
  input  logic [WIDTH_REG-1:0]       i_rs2,
  input  logic                       i_wb_valid0,
  input  logic                       i_wb_valid1,
  input  logic [WIDTH_REG-1:0]       i_wb_tag0,
  input  logic [WIDTH_REG-1:0]       i_wb_tag1,
  output logic                       o_valid1,
  output logic                       o_valid2,
  output logic [WIDTH-1:0]           o_instr1,
  output logic [WIDTH-1:0]           o_instr2,
  output logic [1:0]                 o_unit1,
  output logic [1:0]                 o_unit2,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  import issue_select_pkg::*;

  localparam int EW        = entry_w(WIDTH, WIDTH_REG);
  localparam int CW        = $clog2(DEPTH+1);
  localparam int IW        = $clog2(DEPTH);
  localparam int DCW       = $clog2(DIV_LAT+1);
  localparam int OFF_UNIT  = off_unit(WIDTH_REG);
  localparam int OFF_INSTR = off_instr(WIDTH_REG);
  localparam logic [1:0] DIV_CODE = 2'(DIV_UNIT);

  logic [DEPTH-1:0][EW-1:0]   ent_q;
  logic [DEPTH+1:0][EW-1:0]   ent_x;
  logic [DEPTH-1:0]           ent_v;
  logic [DEPTH-1:0][1:0]      src_sel;
  logic [DEPTH-1:0]           d_valid;
  logic [EW-1:0]              new_ent;
  logic [DCW-1:0]             div_cnt;

  logic                       a_vld, b_vld;
  logic [IW-1:0]              a_idx, b_idx;
  logic [1:0]                 a_unit, b_unit;
  logic [DEPTH-1:0]           elig, rm;
  logic [DEPTH+1:0]           vx, rmx;
  logic [DEPTH+1:0][1:0]      cnt_le;
  logic [1:0]                 run, n_iss;
  logic [CW-1:0]              count_after;
  logic                       enq, div_sel;

  assign o_ready = (o_count < CW'(DEPTH));
  assign enq     = i_valid && o_ready && !i_flush;
  assign new_ent = {i_instr, i_unit, i_rs1, i_rs2, (i_rs1 == '0), (i_rs2 == '0)};
  assign ent_x   = {{2*EW{1'b0}}, ent_q};

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      issue_entry #(.WIDTH(WIDTH), .WIDTH_REG(WIDTH_REG)) u_ent (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_flush),
        .src_sel   (src_sel[g]),
        .d_valid   (d_valid[g]),
        .in_p1     (ent_x[g+1]),
        .in_p2     (ent_x[g+2]),
        .in_new    (new_ent),
        .wb_valid0 (i_wb_valid0),
        .wb_tag0   (i_wb_tag0),
        .wb_valid1 (i_wb_valid1),
        .wb_tag1   (i_wb_tag1),
        .q_valid   (ent_v[g]),
        .q         (ent_q[g])
      );
    end
  endgenerate

  // Priority select: A is the oldest eligible op, B the oldest eligible op on
  // a different unit. The unit-inequality also keeps two divides apart.
  always_comb begin
    elig   = '0;
    a_vld  = 1'b0;
    b_vld  = 1'b0;
    a_idx  = '0;
    b_idx  = '0;
    a_unit = '0;
    b_unit = '0;
    for (int j = 0; j < DEPTH; j++) begin
      elig[j] = ent_v[j] && ent_q[j][OFF_R1] && ent_q[j][OFF_R2] &&
                ((ent_q[j][OFF_UNIT +: 2] != DIV_CODE) || (div_cnt == '0));
      if (elig[j]) begin
        if (!a_vld) begin
          a_vld  = 1'b1;
          a_idx  = IW'(j);
          a_unit = ent_q[j][OFF_UNIT +: 2];
        end else if (!b_vld && (ent_q[j][OFF_UNIT +: 2] != a_unit)) begin
          b_vld  = 1'b1;
          b_idx  = IW'(j);
          b_unit = ent_q[j][OFF_UNIT +: 2];
        end
      end
    end
  end

  assign div_sel     = (a_vld && (a_unit == DIV_CODE)) || (b_vld && (b_unit == DIV_CODE));
  assign n_iss       = {1'b0, a_vld} + {1'b0, b_vld};
  assign count_after = o_count - CW'(n_iss);

  // Collapse: survivor j moves down by the number of removed entries at or
  // below j (0..2). The new entry lands just above the survivors.
  always_comb begin
    for (int j = 0; j < DEPTH; j++)
      rm[j] = (a_vld && (a_idx == IW'(j))) || (b_vld && (b_idx == IW'(j)));
    rmx = {2'b00, rm};
    vx  = {2'b00, ent_v};
    run = 2'd0;
    for (int j = 0; j < DEPTH+2; j++) begin
      run       = run + {1'b0, rmx[j]};
      cnt_le[j] = run;
    end
    for (int i = 0; i < DEPTH; i++) begin
      src_sel[i] = 2'd0;
      d_valid[i] = 1'b0;
      if (enq && (count_after == CW'(i))) begin
        src_sel[i] = 2'd3;
        d_valid[i] = 1'b1;
      end else if (vx[i] && !rmx[i] && (cnt_le[i] == 2'd0)) begin
        d_valid[i] = 1'b1;
      end else if (vx[i+1] && !rmx[i+1] && (cnt_le[i+1] == 2'd1)) begin
        src_sel[i] = 2'd1;
        d_valid[i] = 1'b1;
      end else if (vx[i+2] && !rmx[i+2] && (cnt_le[i+2] == 2'd2)) begin
        src_sel[i] = 2'd2;
        d_valid[i] = 1'b1;
      end
    end
  end

  // div_cnt counts the busy cycles remaining after the issue cycle, so a
  // divide may follow DIV_LAT cycles after the previous one (DIV_LAT=1 gives
  // back-to-back). Flush leaves it alone: the divider is still working.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_count  <= '0;
      div_cnt  <= '0;
      o_valid1 <= 1'b0;
      o_valid2 <= 1'b0;
      o_instr1 <= '0;
      o_instr2 <= '0;
      o_unit1  <= '0;
      o_unit2  <= '0;
    end else begin
      o_count  <= i_flush ? '0 : (count_after + CW'(enq));
      o_valid1 <= a_vld && !i_flush;
      o_valid2 <= b_vld && !i_flush;
      if (a_vld && !i_flush) begin
        o_instr1 <= ent_q[a_idx][OFF_INSTR +: WIDTH];
        o_unit1  <= a_unit;
      end
      if (b_vld && !i_flush) begin
        o_instr2 <= ent_q[b_idx][OFF_INSTR +: WIDTH];
        o_unit2  <= b_unit;
      end
      if (div_sel && !i_flush)
        div_cnt <= DCW'(DIV_LAT - 1);
      else if (div_cnt != '0)
        div_cnt <= div_cnt - DCW'(1);
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// tb_issue_select: directed bench with a per-slot scoreboard. Each expected
// issue carries the cycle it must appear in; every cycle both o_valid bits
// are compared against the scoreboard heads.
module tb_issue_select;

  logic        clk = 1'b0;
  logic        rst, i_flush, i_valid, o_ready;
  logic [31:0] i_instr;
  logic [1:0]  i_unit;
  logic [4:0]  i_rs1, i_rs2, i_wb_tag0, i_wb_tag1;
  logic        i_wb_valid0, i_wb_valid1;
  logic        o_valid1, o_valid2;
  logic [31:0] o_instr1, o_instr2;
  logic [1:0]  o_unit1, o_unit2;
  logic [3:0]  o_count;

  typedef struct {
    int          cyc;
    logic [31:0] instr;
    logic [1:0]  unit;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  issue_select #(.WIDTH(32), .WIDTH_REG(5), .DEPTH(8), .DIV_UNIT(3), .DIV_LAT(8)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_unit(i_unit), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_wb_valid0(i_wb_valid0), .i_wb_valid1(i_wb_valid1),
    .i_wb_tag0(i_wb_tag0), .i_wb_tag1(i_wb_tag1),
    .o_valid1(o_valid1), .o_valid2(o_valid2), .o_instr1(o_instr1), .o_instr2(o_instr2),
    .o_unit1(o_unit1), .o_unit2(o_unit2), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void push(input int slot, input int c, input logic [31:0] ins,
                               input logic [1:0] u);
    exp_t e;
    e.cyc = c; e.instr = ins; e.unit = u;
    if (slot == 1) q1.push_back(e);
    else           q2.push_back(e);
  endfunction

  // Advance one edge, sample 1ns later, compare both slots to the scoreboard.
  task automatic tick();
    logic ev1, ev2;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    ev1 = (q1.size() > 0) && (q1[0].cyc == cyc);
    ev2 = (q2.size() > 0) && (q2[0].cyc == cyc);
    chk("valid1", 32'(o_valid1), 32'(ev1));
    chk("valid2", 32'(o_valid2), 32'(ev2));
    if (ev1) begin
      e = q1.pop_front();
      chk("instr1", o_instr1, e.instr);
      chk("unit1", 32'(o_unit1), 32'(e.unit));
    end
    if (ev2) begin
      e = q2.pop_front();
      chk("instr2", o_instr2, e.instr);
      chk("unit2", 32'(o_unit2), 32'(e.unit));
    end
  endtask

  task automatic enq(input logic [31:0] ins, input logic [1:0] u,
                     input logic [4:0] r1, input logic [4:0] r2);
    i_valid = 1'b1; i_instr = ins; i_unit = u; i_rs1 = r1; i_rs2 = r2;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wake0(input logic [4:0] t);
    i_wb_valid0 = 1'b1; i_wb_tag0 = t;
    tick();
    i_wb_valid0 = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_instr = '0; i_unit = '0;
    i_rs1 = '0; i_rs2 = '0; i_wb_valid0 = 1'b0; i_wb_valid1 = 1'b0;
    i_wb_tag0 = '0; i_wb_tag1 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_instr1", o_instr1, 32'd0);
    chk("rst_instr2", o_instr2, 32'd0);
    chk("rst_unit1", 32'(o_unit1), 32'd0);
    chk("rst_unit2", 32'(o_unit2), 32'd0);

    // Three ops on units 0,1,2 released together by one wakeup.
    enq(32'h100, 2'd0, 5'd9, 5'd0);
    enq(32'h101, 2'd1, 5'd9, 5'd0);
    enq(32'h102, 2'd2, 5'd9, 5'd0);
    chk("t1_count3", 32'(o_count), 32'd3);
    w = cyc;
    push(1, w+2, 32'h100, 2'd0);
    push(2, w+2, 32'h101, 2'd1);
    push(1, w+3, 32'h102, 2'd2);
    wake0(5'd9);
    tick(); chk("t1_count1", 32'(o_count), 32'd1);
    tick(); chk("t1_count0", 32'(o_count), 32'd0);

    // Same unit: one per cycle, always in slot A.
    push(1, cyc+2, 32'h200, 2'd0); enq(32'h200, 2'd0, 5'd0, 5'd0);
    push(1, cyc+2, 32'h201, 2'd0); enq(32'h201, 2'd0, 5'd0, 5'd0);
    tick(); tick();

    // Wakeup on bus 1 at t -> issue at t+2.
    enq(32'h300, 2'd0, 5'd7, 5'd0);
    tick(); tick();
    w = cyc;
    push(1, w+2, 32'h300, 2'd0);
    i_wb_valid1 = 1'b1; i_wb_tag1 = 5'd7;
    tick();
    i_wb_valid1 = 1'b0;
    tick();

    // Same tag on both buses, then the second source a cycle later.
    enq(32'h301, 2'd1, 5'd12, 5'd13);
    w = cyc;
    push(1, w+3, 32'h301, 2'd1);
    i_wb_valid0 = 1'b1; i_wb_tag0 = 5'd12; i_wb_valid1 = 1'b1; i_wb_tag1 = 5'd12;
    tick();
    i_wb_tag0 = 5'd13; i_wb_valid1 = 1'b0;
    tick();
    i_wb_valid0 = 1'b0;
    tick();

    // Wakeup arriving in the enqueue cycle.
    w = cyc;
    push(1, w+2, 32'h302, 2'd2);
    i_wb_valid0 = 1'b1; i_wb_tag0 = 5'd14; i_wb_valid1 = 1'b1; i_wb_tag1 = 5'd15;
    enq(32'h302, 2'd2, 5'd14, 5'd15);
    i_wb_valid0 = 1'b0; i_wb_valid1 = 1'b0;
    tick();

    // Divider occupancy: second divide 8 cycles after the first, ALU op between.
    w = cyc;
    push(1, w+2,  32'h400, 2'd3);
    push(1, w+4,  32'h402, 2'd0);
    push(1, w+10, 32'h401, 2'd3);
    enq(32'h400, 2'd3, 5'd0, 5'd0);
    enq(32'h401, 2'd3, 5'd0, 5'd0);
    enq(32'h402, 2'd0, 5'd0, 5'd0);
    repeat (8) tick();

    // Fill to DEPTH; extra enqueues (including one in an issue cycle) refused.
    enq(32'h500, 2'd0, 5'd21, 5'd0);
    for (int k = 1; k < 8; k++) enq(32'h500 + 32'(k), 2'd1, 5'd20, 5'd0);
    chk("full_count", 32'(o_count), 32'd8);
    chk("full_ready", 32'(o_ready), 32'd0);
    enq(32'h5FF, 2'd2, 5'd0, 5'd0);
    chk("full_drop_count", 32'(o_count), 32'd8);
    w = cyc;
    push(1, w+2, 32'h500, 2'd0);
    wake0(5'd21);
    chk("full_ready_still0", 32'(o_ready), 32'd0);
    enq(32'h5FE, 2'd2, 5'd0, 5'd0);
    chk("free_count7", 32'(o_count), 32'd7);
    chk("free_ready", 32'(o_ready), 32'd1);
    w = cyc;
    for (int k = 1; k < 8; k++) push(1, w+1+k, 32'h500 + 32'(k), 2'd1);
    wake0(5'd20);
    repeat (8) tick();
    chk("drain_count", 32'(o_count), 32'd0);

    // Flush with 5 queued and a divide in flight.
    w = cyc;
    push(1, w+2,  32'h600, 2'd3);
    push(1, w+10, 32'h610, 2'd3);
    enq(32'h600, 2'd3, 5'd0, 5'd0);
    for (int k = 1; k < 6; k++) enq(32'h600 + 32'(k), 2'd0, 5'd30, 5'd0);
    chk("pre_flush_count", 32'(o_count), 32'd5);
    i_flush = 1'b1; i_wb_valid0 = 1'b1; i_wb_tag0 = 5'd30;
    enq(32'h6FF, 2'd0, 5'd0, 5'd0);
    i_flush = 1'b0; i_wb_valid0 = 1'b0;
    chk("flush_count", 32'(o_count), 32'd0);
    chk("flush_ready", 32'(o_ready), 32'd1);
    enq(32'h610, 2'd3, 5'd0, 5'd0);
    repeat (10) tick();

    chk("sb_empty", 32'(q1.size() + q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
